timer_multi: RTL and testbench

- Parametrised multi-channel, memory-mapped timer; next generation of the single-channel peripheral timer on the processor's I/O bus.
- N_CH independent up-counters, each with:
  - a per-channel prescaler;
  - periodic or one-shot mode;
  - reload-on-overflow;
  - a sticky pending flag.
- Per-channel interrupt vector plus an OR-reduced request for the interrupt controller.
- Zero-wait-state bus slave, same handshake as the existing peripherals.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_channel.sv | 149 ++++++++++++++
 rtl/timer_multi.sv | 108 ++++++++++
 tb/tb_timer_multi.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Register map and CTRL/STATUS bit positions for timer_multi.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_RELOAD = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;
    localparam logic [2:0] REG_CMP    = 3'd4;

    localparam int CTRL_RUN       = 0;
    localparam int CTRL_INTEN     = 1;
    localparam int CTRL_ONESHOT   = 2;
    localparam int CTRL_PRESC_LSB = 8;

    localparam int STATUS_PENDING = 0;

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : timer_channel
// Brief    : One timer channel: prescaler, counter, RELOAD/CMP, CTRL, pending.
//            CMP register and PWM output exist only with TIMER_MULTI_PWM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we_ctrl,
    input  logic        i_we_status,
    input  logic        i_we_reload,
    input  logic        i_we_count,
    input  logic        i_we_cmp,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_ctrl_rd,
    output logic [15:0] o_reload_rd,
    output logic [15:0] o_count_rd,
    output logic [15:0] o_cmp_rd,
    output logic        o_pending,
    output logic        o_int,
    output logic        o_pwm
);

    localparam int PW = (PRESC_W > 0) ? PRESC_W : 1;

    logic             r_run;
    logic             r_int_en;
    logic             r_oneshot;
    logic             r_pending;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    r_presc_cnt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;

    logic [PW-1:0]    w_presc_wr;
    logic             w_tick;
    logic             w_ovf;
    logic             w_unused;

    generate
        if (PRESC_W > 0) begin : g_presc_field
            assign w_presc_wr = i_wdata[CTRL_PRESC_LSB +: PW];
        end else begin : g_no_presc_field
            assign w_presc_wr = '0;
        end
    endgenerate

    assign w_tick   = r_run && (r_presc_cnt == r_presc);
    // A COUNT write on the same edge suppresses the overflow entirely.
    assign w_ovf    = w_tick && (&r_count) && !i_we_count;
    assign w_unused = &{1'b0, i_wdata, i_we_cmp};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run       <= 1'b0;
            r_int_en    <= 1'b0;
            r_oneshot   <= 1'b0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_count     <= '0;
            r_reload    <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (i_we_ctrl) begin
                r_run     <= i_wdata[CTRL_RUN];
                r_int_en  <= i_wdata[CTRL_INTEN];
                r_oneshot <= i_wdata[CTRL_ONESHOT];
                r_presc   <= w_presc_wr;
            end else if (w_ovf && r_oneshot) begin
                r_run <= 1'b0;
            end

            if (i_we_ctrl || i_we_count || !r_run || w_tick) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + PW'(1);
            end

            if (i_we_count) begin
                r_count <= i_wdata[WIDTH-1:0];
            end else if (w_ovf) begin
                r_count <= r_reload;
            end else if (w_tick) begin
                r_count <= r_count + WIDTH'(1);
            end

            if (i_we_reload) begin
                r_reload <= i_wdata[WIDTH-1:0];
            end

            // Set beats a simultaneous W1C so no overflow is lost.
            if (w_ovf) begin
                r_pending <= 1'b1;
            end else if (i_we_status && i_wdata[STATUS_PENDING]) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        o_ctrl_rd                         = '0;
        o_ctrl_rd[CTRL_RUN]               = r_run;
        o_ctrl_rd[CTRL_INTEN]             = r_int_en;
        o_ctrl_rd[CTRL_ONESHOT]           = r_oneshot;
        o_ctrl_rd[CTRL_PRESC_LSB +: PW]   = r_presc;
        o_reload_rd                       = '0;
        o_reload_rd[WIDTH-1:0]            = r_reload;
        o_count_rd                        = '0;
        o_count_rd[WIDTH-1:0]             = r_count;
    end

    assign o_pending = r_pending;
    assign o_int     = r_pending && r_int_en;

`ifdef TIMER_MULTI_PWM_EN
    logic [WIDTH-1:0] r_cmp;
    logic             r_pwm;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmp <= '0;
            r_pwm <= 1'b0;
        end else begin
            if (i_we_cmp) begin
                r_cmp <= i_wdata[WIDTH-1:0];
            end
            r_pwm <= r_run && (r_count >= r_cmp);
        end
    end

    always_comb begin
        o_cmp_rd            = '0;
        o_cmp_rd[WIDTH-1:0] = r_cmp;
    end
    assign o_pwm = r_pwm;
`else
    assign o_cmp_rd = '0;
    assign o_pwm    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi
// Brief    : N_CH-channel memory-mapped timer with per-channel interrupts.
//            Optional CMP/PWM per channel via macro TIMER_MULTI_PWM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module timer_multi
    import timer_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 3 + $clog2(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata,
    output logic              o_rdy,
    output logic [N_CH-1:0]   o_int_vec,
    output logic              o_int_req,
    output logic [N_CH-1:0]   o_pwm
);

    localparam int CH_W = (ADDR_W > 3) ? ADDR_W - 3 : 1;

    logic [CH_W-1:0] w_ch;
    logic [2:0]      w_off;
    logic [15:0]     w_rdata;

    logic [15:0]     w_ctrl_rd   [N_CH];
    logic [15:0]     w_reload_rd [N_CH];
    logic [15:0]     w_count_rd  [N_CH];
    logic [15:0]     w_cmp_rd    [N_CH];
    logic [N_CH-1:0] w_pending;
    logic [N_CH-1:0] w_int;
    logic [N_CH-1:0] w_pwm;

    assign w_off = i_addr[2:0];

    generate
        if (ADDR_W > 3) begin : g_ch_field
            assign w_ch = i_addr[ADDR_W-1:3];
        end else begin : g_single_ch
            assign w_ch = '0;
        end
    endgenerate

    // Channel indices at or above N_CH match no instance, so they decode to nothing.
    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic w_wr;
            assign w_wr = i_sel && i_we && (w_ch == CH_W'(c));

            timer_channel #(
                .WIDTH   (WIDTH),
                .PRESC_W (PRESC_W)
            ) u_channel (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_we_ctrl   (w_wr && (w_off == REG_CTRL)),
                .i_we_status (w_wr && (w_off == REG_STATUS)),
                .i_we_reload (w_wr && (w_off == REG_RELOAD)),
                .i_we_count  (w_wr && (w_off == REG_COUNT)),
                .i_we_cmp    (w_wr && (w_off == REG_CMP)),
                .i_wdata     (i_wdata),
                .o_ctrl_rd   (w_ctrl_rd[c]),
                .o_reload_rd (w_reload_rd[c]),
                .o_count_rd  (w_count_rd[c]),
                .o_cmp_rd    (w_cmp_rd[c]),
                .o_pending   (w_pending[c]),
                .o_int       (w_int[c]),
                .o_pwm       (w_pwm[c])
            );
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        if (i_sel && i_re) begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_ch == CH_W'(c)) begin
                    case (w_off)
                        REG_CTRL:   w_rdata = w_ctrl_rd[c];
                        REG_STATUS: w_rdata[STATUS_PENDING] = w_pending[c];
                        REG_RELOAD: w_rdata = w_reload_rd[c];
                        REG_COUNT:  w_rdata = w_count_rd[c];
                        REG_CMP:    w_rdata = w_cmp_rd[c];
                        default:    w_rdata = '0;
                    endcase
                end
            end
        end
    end

    assign o_rdata   = w_rdata;
    assign o_rdy     = i_sel;
    assign o_int_vec = w_int;
    assign o_int_req = |w_int;
    assign o_pwm     = w_pwm;

endmodule
`default_nettype wire

// File: tb/tb_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_multi
// Brief    : Directed self-checking bench for timer_multi (4 channels, 6-bit
//            address so that out-of-range channel indices can be driven).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_multi;

    localparam int N_CH   = 4;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sel = 1'b0;
    logic              we  = 1'b0;
    logic              re  = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [15:0]       wdata = '0;
    logic [15:0]       rdata;
    logic              rdy;
    logic [N_CH-1:0]   int_vec;
    logic              int_req;
    logic [N_CH-1:0]   pwm;

    int checks = 0;
    int errors = 0;

    timer_multi #(
        .N_CH    (N_CH),
        .WIDTH   (16),
        .PRESC_W (8),
        .ADDR_W  (ADDR_W)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sel     (sel),
        .i_we      (we),
        .i_re      (re),
        .i_addr    (addr),
        .i_wdata   (wdata),
        .o_rdata   (rdata),
        .o_rdy     (rdy),
        .o_int_vec (int_vec),
        .o_int_req (int_req),
        .o_pwm     (pwm)
    );

    always #5 clk = ~clk;

    localparam int CTRL = 0, STATUS = 1, RELOAD = 2, COUNT = 3, CMP = 4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int off, input logic [15:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = ADDR_W'((ch << 3) | off);
        wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0;
        we  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int ch, input int off, input logic [15:0] exp);
        sel  = 1'b1;
        re   = 1'b1;
        addr = ADDR_W'((ch << 3) | off);
        #1;
        check(tag, 32'(rdata), 32'(exp));
        sel = 1'b0;
        re  = 1'b0;
        #1;
    endtask

    initial begin
        int   pwm_hi;
        logic pwm_k8;
        logic pwm_k9;

        // Reset
        cyc(3);
        check("rst_int_req", 32'(int_req), 32'h0);
        check("rst_pwm", 32'(pwm), 32'h0);
        rst = 1'b0;
        cyc(1);
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int off = 0; off < 5; off++) begin
                rd_chk("rst_reg", ch, off, 16'h0000);
            end
        end
        check("rst_int_vec", 32'(int_vec), 32'h0);
        check("rst_rdata_idle", 32'(rdata), 32'h0);
        cyc(100);
        rd_chk("idle_count", 0, COUNT, 16'h0000);
        check("idle_int_req", 32'(int_req), 32'h0);

        // ch0 periodic, presc 0
        wr(0, RELOAD, 16'hFFF0);
        wr(0, COUNT, 16'hFFFC);
        wr(0, CTRL, 16'h0003);
        rd_chk("ch0_count_start", 0, COUNT, 16'hFFFC);
        cyc(3);
        rd_chk("ch0_count_3", 0, COUNT, 16'hFFFF);
        check("ch0_no_int_yet", 32'(int_req), 32'h0);
        cyc(1);
        rd_chk("ch0_ovf_count", 0, COUNT, 16'hFFF0);
        rd_chk("ch0_ovf_pending", 0, STATUS, 16'h0001);
        check("ch0_int_vec", 32'(int_vec), 32'h1);
        check("ch0_int_req", 32'(int_req), 32'h1);
        wr(0, STATUS, 16'h0001);
        rd_chk("ch0_w1c", 0, STATUS, 16'h0000);
        check("ch0_w1c_int", 32'(int_req), 32'h0);
        cyc(14);
        rd_chk("ch0_pre_ovf2", 0, COUNT, 16'hFFFF);
        cyc(1);
        rd_chk("ch0_ovf2_count", 0, COUNT, 16'hFFF0);
        rd_chk("ch0_ovf2_pending", 0, STATUS, 16'h0001);
        wr(0, CTRL, 16'h0000);
        wr(0, STATUS, 16'h0001);
        rd_chk("ch0_stop_pending", 0, STATUS, 16'h0000);
        check("ch0_stop_int", 32'(int_req), 32'h0);

        // ch2 one-shot, presc 4
        wr(2, RELOAD, 16'h1234);
        wr(2, COUNT, 16'hFFFE);
        wr(2, CTRL, 16'h0407);
        cyc(4);
        rd_chk("ch2_before_tick", 2, COUNT, 16'hFFFE);
        cyc(1);
        rd_chk("ch2_tick1", 2, COUNT, 16'hFFFF);
        cyc(4);
        rd_chk("ch2_no_ovf_yet", 2, STATUS, 16'h0000);
        cyc(1);
        rd_chk("ch2_ovf_count", 2, COUNT, 16'h1234);
        rd_chk("ch2_ovf_ctrl", 2, CTRL, 16'h0406);
        rd_chk("ch2_ovf_pending", 2, STATUS, 16'h0001);
        check("ch2_int_vec", 32'(int_vec), 32'h4);
        cyc(20);
        rd_chk("ch2_hold", 2, COUNT, 16'h1234);
        wr(2, STATUS, 16'h0001);
        check("ch2_clr_int", 32'(int_req), 32'h0);

        // ch1: W1C on the overflow edge
        wr(1, COUNT, 16'hFFFE);
        wr(1, CTRL, 16'h0003);
        cyc(1);
        wr(1, STATUS, 16'h0001);
        rd_chk("ch1_set_wins", 1, STATUS, 16'h0001);
        rd_chk("ch1_reload0", 1, COUNT, 16'h0000);
        wr(1, CTRL, 16'h0000);
        check("ch1_masked_vec", 32'(int_vec), 32'h0);
        check("ch1_masked_req", 32'(int_req), 32'h0);
        rd_chk("ch1_still_pending", 1, STATUS, 16'h0001);
        wr(1, CTRL, 16'h0002);
        check("ch1_unmask_req", 32'(int_req), 32'h1);
        check("ch1_unmask_vec", 32'(int_vec), 32'h2);
        wr(1, STATUS, 16'h0001);
        check("ch1_clr_req", 32'(int_req), 32'h0);

        // ch3: COUNT write on a tick edge
        wr(3, CTRL, 16'h0001);
        cyc(2);
        rd_chk("ch3_running", 3, COUNT, 16'h0002);
        wr(3, COUNT, 16'h5555);
        rd_chk("ch3_write_wins", 3, COUNT, 16'h5555);
        cyc(1);
        rd_chk("ch3_resume", 3, COUNT, 16'h5556);
        wr(3, COUNT, 16'hFFFF);
        wr(3, COUNT, 16'h0100);
        rd_chk("ch3_ovf_suppressed", 3, COUNT, 16'h0100);
        rd_chk("ch3_no_pending", 3, STATUS, 16'h0000);
        cyc(1);
        rd_chk("ch3_after", 3, COUNT, 16'h0101);
        wr(3, CTRL, 16'h0000);

        // Out-of-range channel and reserved offset
        wr(5, CTRL, 16'h0003);
        wr(5, RELOAD, 16'hBEEF);
        wr(5, COUNT, 16'h1111);
        rd_chk("ch5_ctrl", 5, CTRL, 16'h0000);
        rd_chk("ch5_reload", 5, RELOAD, 16'h0000);
        rd_chk("ch1_ctrl_intact", 1, CTRL, 16'h0002);
        rd_chk("ch1_reload_intact", 1, RELOAD, 16'h0000);
        check("oor_int_req", 32'(int_req), 32'h0);
        wr(0, 5, 16'hFFFF);
        rd_chk("reserved_off", 0, 5, 16'h0000);
        rd_chk("ch7_read", 7, COUNT, 16'h0000);

        // PWM on ch0: RELOAD 0xFFF0, CMP 0xFFF8
        wr(0, CMP, 16'hFFF8);
        wr(0, COUNT, 16'hFFF0);
        wr(0, CTRL, 16'h0001);
        pwm_hi = 0;
        pwm_k8 = 1'b0;
        pwm_k9 = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            cyc(1);
            if (pwm[0]) pwm_hi++;
            if (k == 8) pwm_k8 = pwm[0];
            if (k == 9) pwm_k9 = pwm[0];
        end
        check("pwm_other_ch", 32'(pwm[3:1]), 32'h0);
`ifdef TIMER_MULTI_PWM_EN
        rd_chk("pwm_cmp_read", 0, CMP, 16'hFFF8);
        check("pwm_high_cycles", 32'(pwm_hi), 32'd16);
        check("pwm_k8_low", 32'(pwm_k8), 32'h0);
        check("pwm_k9_high", 32'(pwm_k9), 32'h1);
`else
        rd_chk("pwm_cmp_read", 0, CMP, 16'h0000);
        check("pwm_high_cycles", 32'(pwm_hi), 32'd0);
        check("pwm_k9_low", 32'(pwm_k9), 32'h0);
`endif
        wr(0, CTRL, 16'h0000);
        wr(0, STATUS, 16'h0001);
        check("final_int_req", 32'(int_req), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
